decoder: RTL and testbench
==========================

DECODER -- requirements
Module: decoder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the codeword input and data output width.
REQ-002 Parameter AMBA_WORD, default 32, SHALL set the CodeWord_Width register width.
REQ-003 reset input 1: asynchronous, active-low.
REQ-004 clk input 1: clock; all state SHALL update on the rising edge.
REQ-005 data_in input DATA_WIDTH: received codeword.
REQ-006 CodeWord_Width input AMBA_WORD: only bits [1:0] SHALL be used; 00 = 8-bit codeword, 01 = 16-bit, 10 = 32-bit, 11 = illegal.
REQ-007 En input 1: start request, sampled in IDLE only.
REQ-008 data_out output DATA_WIDTH: decoded data, right-aligned, upper bits zero.
REQ-009 num_of_errors output 2: 0 = clean, 1 = single error corrected, 2 = double error detected.
REQ-010 ready_Decoder output 1: one-cycle result-valid pulse.
REQ-011 busy output 1: high whenever state is not IDLE.

Function
REQ-012 Codeword layout SHALL be: P = 4/5/6 parity bits at codeword bits [P-1:0] for 8/16/32; bit P-1 = overall parity; data bits d[K-1:0] at bits [W-1:P]; K = 4/11/26.
REQ-013 Codeword bits at or above the active width W SHALL be ignored.
REQ-014 Data bit dk SHALL occupy Hamming position h(k), the (k+1)-th positive integer that is not a power of two (d0->3, d1->5, d3->7, d25->31).
REQ-015 Syndrome bit i (i < P-1) SHALL equal parity bit i XOR every dk whose h(k) has bit i set.
REQ-016 Q SHALL be the XOR of all W active codeword bits.
REQ-017 Classification: S=0 and Q=0 -> 0 errors; Q=1 -> 1 error; S!=0 and Q=0 -> 2 errors.
REQ-018 Single error with S=0, or with S a power of two: data SHALL pass unmodified (the error is in a parity bit).
REQ-019 Single error with S not a power of two: data bit k = S - floor(log2 S) - 2 SHALL be inverted.
REQ-020 A single error with k >= K (S outside the range for the width) SHALL be reported as 2 errors, with data uncorrected.
REQ-021 Double error: data_out SHALL carry the raw, uncorrected data bits.
REQ-022 FSM states SHALL be IDLE, SYND, CORR, DONE.
REQ-023 IDLE with En=1 at edge T: register data_in and CodeWord_Width[1:0], then go to SYND.
REQ-024 SYND -> CORR at edge T+1: register S and Q.
REQ-025 CORR -> DONE at edge T+2: update data_out and num_of_errors; ready_Decoder=1 during the DONE cycle.
REQ-026 DONE -> IDLE unconditionally at edge T+3; ready_Decoder returns to 0.
REQ-027 Latency SHALL be 3 cycles from the En-sampling edge to ready_Decoder high; maximum throughput is one codeword per 4 cycles.
REQ-028 En while busy SHALL be ignored and not queued; data_in changes after capture SHALL NOT affect the result.
REQ-029 data_out and num_of_errors SHALL hold their value until the next DONE or reset.
REQ-030 Illegal width (11): data_out=0, num_of_errors=0, with ready_Decoder still pulsed at normal latency.

Reset
REQ-031 reset low SHALL asynchronously force state=IDLE, data_out=0, num_of_errors=0, ready_Decoder=0, busy=0, and clear the internal registers.
REQ-032 Reset mid-operation SHALL abort the decode; no ready_Decoder pulse SHALL follow the release.
REQ-033 After release, the first En in IDLE SHALL start a fresh decode.

Verification
REQ-034 Width 00, data_in=0xB1, En pulse -> 3 cycles later ready_Decoder=1, data_out=0x0B, num_of_errors=0.
REQ-035 Width 00, data_in=0xF1 (bit 6 flipped) -> data_out=0x0B, num_of_errors=1; data_in=0xB9 (overall parity flipped) -> data_out=0x0B, num_of_errors=1.
REQ-036 Width 00, data_in=0x81 (bits 4,5 flipped) -> data_out=0x08, num_of_errors=2.
REQ-037 Width 10, data_in=0x80000000 (d25 flipped in the all-zero codeword) -> data_out=0, num_of_errors=1; data_in=0 -> num_of_errors=0.
REQ-038 En held high continuously -> a decode starts every 4 cycles and ready_Decoder pulses once per decode; reset asserted in SYND -> no pulse, all outputs 0.
REQ-039 Random legal-width codewords with 0, 1 or 2 injected flips SHALL be compared against a reference model for all three widths, including flips above W (ignored).

Source files
------------

// File: rtl/decoder_if.sv
// Bus bundle for the Hamming SECDED decoder: codeword/width/start in,
// decoded data, error class, result pulse and busy out.
//
// Handshake: the master raises En with data_in/CodeWord_Width valid; the
// decoder accepts only while busy is low (IDLE). Accepted requests produce
// exactly one ready_Decoder pulse three clocks later. En while busy is
// dropped, never queued. data_out/num_of_errors are valid during the
// ready_Decoder cycle and hold until the next result.
interface decoder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int AMBA_WORD  = 32
);
    logic [DATA_WIDTH-1:0] data_in;
    logic [AMBA_WORD-1:0]  CodeWord_Width;
    logic                  En;
    logic [DATA_WIDTH-1:0] data_out;
    logic [1:0]            num_of_errors;
    logic                  ready_Decoder;
    logic                  busy;
    logic [1:0]            dbg_state;

    modport master (
        output data_in, CodeWord_Width, En,
        input  data_out, num_of_errors, ready_Decoder, busy, dbg_state
    );

    modport slave (
        input  data_in, CodeWord_Width, En,
        output data_out, num_of_errors, ready_Decoder, busy, dbg_state
    );
endinterface

// File: rtl/decoder.sv
// Hamming SECDED decoder for 8/16/32-bit codewords. Parity bits sit at the
// bottom of the codeword (top one is overall parity), data bits above them.
// Four-state FSM: IDLE capture -> SYND syndrome -> CORR correct -> DONE pulse.
module decoder #(
    parameter int DATA_WIDTH = 32,
    parameter int AMBA_WORD  = 32
) (
    input  logic clk,
    input  logic reset,
    decoder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SYND, CORR, DONE} state_t;

    state_t state, state_nx;

    logic [31:0]           cw_q;
    logic [1:0]            wsel_q;
    logic [4:0]            s_q;
    logic                  q_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [1:0]            nerr_q;

    logic [31:0] din32;
    logic [25:0] d_raw;
    logic [4:0]  par;
    logic [4:0]  s_nx;
    logic        q_nx;
    logic [25:0] dat_nx;
    logic [1:0]  nerr_nx;
    int          k_n;
    int          k_fix;

    // Only the two low width-select bits carry meaning.
    logic unused_width_bits;
    assign unused_width_bits = ^bus.CodeWord_Width[AMBA_WORD-1:2];

    assign din32 = 32'(bus.data_in);

    // Bits at or above the active width are cleared on capture so they can
    // never reach the syndrome or the overall parity.
    function automatic logic [31:0] width_mask(input logic [1:0] w);
        case (w)
            2'b00:   return 32'h0000_00FF;
            2'b01:   return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Hamming position of data bit k: skip 1,2,4,8,16.
    function automatic logic [4:0] hpos(input int k);
        int h;
        h = k + 3 + ((k >= 1) ? 1 : 0) + ((k >= 4) ? 1 : 0) + ((k >= 11) ? 1 : 0);
        return h[4:0];
    endfunction

    function automatic int flog2(input logic [4:0] s);
        casez (s)
            5'b1????: return 4;
            5'b01???: return 3;
            5'b001??: return 2;
            5'b0001?: return 1;
            default:  return 0;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: one pass through the pipeline per accepted request.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.En) state_nx = SYND;
            SYND:    state_nx = CORR;
            CORR:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Split captured codeword into parity and right-aligned data bits.
    always_comb begin
        d_raw = '0;
        par   = '0;
        k_n   = 26;
        case (wsel_q)
            2'b00: begin
                d_raw = {22'b0, cw_q[7:4]};
                par   = {2'b0, cw_q[2:0]};
                k_n   = 4;
            end
            2'b01: begin
                d_raw = {15'b0, cw_q[15:5]};
                par   = {1'b0, cw_q[3:0]};
                k_n   = 11;
            end
            default: begin
                d_raw = cw_q[31:6];
                par   = cw_q[4:0];
                k_n   = 26;
            end
        endcase
    end

    // Syndrome: parity bits XOR the Hamming positions of every set data bit.
    always_comb begin
        s_nx = par;
        for (int k = 0; k < 26; k++) begin
            if (d_raw[k]) s_nx = s_nx ^ hpos(k);
        end
        q_nx = ^cw_q;
    end

    // Error classification and single-bit correction.
    always_comb begin
        dat_nx  = d_raw;
        nerr_nx = 2'd0;
        k_fix   = 32'(s_q) - flog2(s_q) - 2;
        if (wsel_q == 2'b11) begin
            dat_nx  = '0;
            nerr_nx = 2'd0;
        end else if (!q_q) begin
            nerr_nx = (s_q != 5'd0) ? 2'd2 : 2'd0;
        end else if ((s_q & (s_q - 5'd1)) == 5'd0) begin
            // S of zero or a power of two: the flip is in a parity bit.
            nerr_nx = 2'd1;
        end else if (k_fix >= k_n) begin
            nerr_nx = 2'd2;
        end else begin
            nerr_nx = 2'd1;
            dat_nx  = d_raw ^ (26'd1 << k_fix);
        end
    end

    // Datapath registers, each loaded in the state that owns it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cw_q   <= '0;
            wsel_q <= '0;
            s_q    <= '0;
            q_q    <= 1'b0;
            data_q <= '0;
            nerr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.En) begin
                        cw_q   <= din32 & width_mask(bus.CodeWord_Width[1:0]);
                        wsel_q <= bus.CodeWord_Width[1:0];
                    end
                end
                SYND: begin
                    s_q <= s_nx;
                    q_q <= q_nx;
                end
                CORR: begin
                    data_q <= DATA_WIDTH'(dat_nx);
                    nerr_q <= nerr_nx;
                end
                default: ;
            endcase
        end
    end

    assign bus.data_out      = data_q;
    assign bus.num_of_errors = nerr_q;
    assign bus.ready_Decoder = (state == DONE);
    assign bus.busy          = (state != IDLE);
    assign bus.dbg_state     = state;

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for the SECDED decoder: directed vectors, throughput,
// mid-decode reset and randomly encoded codewords with injected flips.
module tb_decoder;

    logic clk;
    logic reset;

    decoder_if #(.DATA_WIDTH(32), .AMBA_WORD(32)) bus();

    decoder #(.DATA_WIDTH(32), .AMBA_WORD(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt = 0;
    logic [33:0] exp_q[$];

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Scoreboard: every result pulse pops one expectation.
    always @(negedge clk) begin
        if (reset && bus.ready_Decoder) begin
            logic [33:0] e;
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("data_out", bus.data_out, e[31:0]);
                check("num_of_errors", {30'b0, bus.num_of_errors}, {30'b0, e[33:32]});
            end
        end
    end

    // Reference encoder: data bits in Hamming order skipping powers of two.
    function automatic logic [31:0] encode(input logic [1:0] w, input logic [25:0] d);
        int p, kn, kk;
        logic [31:0] cw;
        p  = (w == 2'd0) ? 4 : (w == 2'd1) ? 5 : 6;
        kn = (w == 2'd0) ? 4 : (w == 2'd1) ? 11 : 26;
        cw = '0;
        kk = 0;
        for (int pos = 1; pos < 32; pos++) begin
            if ($countones(pos) != 1 && kk < kn) begin
                if (d[kk]) begin
                    cw[p + kk] = 1'b1;
                    for (int i = 0; i < p - 1; i++) begin
                        if (pos[i]) cw[i] = ~cw[i];
                    end
                end
                kk++;
            end
        end
        cw[p - 1] = ^cw;
        return cw;
    endfunction

    // One full request with latency and busy checks.
    task automatic do_decode(input logic [1:0] w, input logic [31:0] cw,
                             input logic [31:0] exp_d, input logic [1:0] exp_e);
        exp_q.push_back({exp_e, exp_d});
        @(negedge clk);
        bus.CodeWord_Width = {30'b0, w};
        bus.data_in        = cw;
        bus.En             = 1'b1;
        @(negedge clk);
        bus.En             = 1'b0;
        bus.data_in        = $urandom();
        bus.CodeWord_Width = 32'($urandom_range(0, 3));
        check("busy_synd", {31'b0, bus.busy}, 32'd1);
        check("ready_early1", {31'b0, bus.ready_Decoder}, 32'd0);
        @(negedge clk);
        check("ready_early2", {31'b0, bus.ready_Decoder}, 32'd0);
        @(negedge clk);
        check("ready_latency", {31'b0, bus.ready_Decoder}, 32'd1);
        @(negedge clk);
        check("ready_drop", {31'b0, bus.ready_Decoder}, 32'd0);
        check("busy_idle", {31'b0, bus.busy}, 32'd0);
    endtask

    initial begin
        int p0;
        logic [1:0]  w;
        int          wbits, p, kn, nf, f1, f2;
        logic [31:0] dm, d, cw, cwe, wm, exp_d;

        reset              = 1'b0;
        bus.En             = 1'b0;
        bus.data_in        = '0;
        bus.CodeWord_Width = '0;
        repeat (3) @(negedge clk);
        check("rst_data_out", bus.data_out, 32'd0);
        check("rst_nerr", {30'b0, bus.num_of_errors}, 32'd0);
        check("rst_ready", {31'b0, bus.ready_Decoder}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed vectors.
        do_decode(2'd0, 32'h0000_00B1, 32'h0B, 2'd0);
        do_decode(2'd0, 32'h0000_00F1, 32'h0B, 2'd1);
        do_decode(2'd0, 32'h0000_00B9, 32'h0B, 2'd1);
        do_decode(2'd0, 32'h0000_0081, 32'h08, 2'd2);
        do_decode(2'd0, 32'hFFFF_FFB1, 32'h0B, 2'd0);
        do_decode(2'd2, 32'h8000_0000, 32'h0, 2'd1);
        do_decode(2'd2, 32'h0000_0000, 32'h0, 2'd0);
        do_decode(2'd1, 32'h0000_0000, 32'h0, 2'd0);
        do_decode(2'd0, 32'h0000_00B1, 32'h0B, 2'd0);
        repeat (3) @(negedge clk);
        check("hold_data_out", bus.data_out, 32'h0B);
        do_decode(2'd3, 32'h0000_00B1, 32'h0, 2'd0);

        // En held high: a new decode every four cycles.
        for (int i = 0; i < 3; i++) exp_q.push_back({2'd1, 32'h0B});
        p0 = pulse_cnt;
        @(negedge clk);
        bus.CodeWord_Width = 32'd0;
        bus.data_in        = 32'h0000_00F1;
        bus.En             = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        bus.En = 1'b0;
        repeat (4) @(negedge clk);
        check("en_held_pulses", 32'(pulse_cnt - p0), 32'd3);

        // Reset in SYND aborts the decode.
        @(negedge clk);
        bus.CodeWord_Width = 32'd0;
        bus.data_in        = 32'h0000_00B1;
        bus.En             = 1'b1;
        @(negedge clk);
        bus.En = 1'b0;
        check("abort_in_synd", {30'b0, bus.dbg_state}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_data_out", bus.data_out, 32'd0);
        check("abort_nerr", {30'b0, bus.num_of_errors}, 32'd0);
        check("abort_ready", {31'b0, bus.ready_Decoder}, 32'd0);
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        p0 = pulse_cnt;
        repeat (6) @(negedge clk);
        check("abort_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        do_decode(2'd0, 32'h0000_0081, 32'h08, 2'd2);

        // Random encoded codewords with 0/1/2 flips plus garbage above W.
        for (int it = 0; it < 60; it++) begin
            w     = 2'($urandom_range(0, 2));
            wbits = 8 << w;
            p     = (w == 2'd0) ? 4 : (w == 2'd1) ? 5 : 6;
            kn    = (w == 2'd0) ? 4 : (w == 2'd1) ? 11 : 26;
            dm    = (32'd1 << kn) - 32'd1;
            d     = $urandom() & dm;
            cw    = encode(w, d[25:0]);
            nf    = $urandom_range(0, 2);
            f1    = $urandom_range(0, wbits - 1);
            f2    = (f1 + $urandom_range(1, wbits - 1)) % wbits;
            cwe   = cw;
            if (nf >= 1) cwe[f1] = ~cwe[f1];
            if (nf == 2) cwe[f2] = ~cwe[f2];
            exp_d = (nf == 2) ? ((cwe >> p) & dm) : d;
            if (wbits < 32) begin
                wm  = (32'd1 << wbits) - 32'd1;
                cwe = cwe | ($urandom() & ~wm);
            end
            do_decode(w, cwe, exp_d, 2'(nf));
        end

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
